// File: rtl/ap3216_i2c_responder.sv
// ap3216_i2c_responder: I2C target emulating the AP3216 ambient-light sensor.
// SCL/SDA are oversampled on I_clk, synchronised and glitch-filtered. The
// target answers writes and combined write / repeated-START / read transfers
// against a small register file (0x00 system config, 0x0C/0x0D ALS data).
//
// Ports:
//   I_clk       system clock (at least 16x SCL)
//   I_rst       synchronous active-high reset
//   I_scl/I_sda raw bus lines from the pads
//   O_sda_oe    1 = pull SDA low, 0 = release (open drain)
//   I_als_data  live 16-bit ALS value (0x0C low byte, 0x0D high byte)
//   O_sys_cfg   current content of register 0x00
//   O_cfg_wr    one-cycle pulse after a byte is written to 0x00
//   O_busy      high from START to STOP
//
// Build option: define AP3216_SHADOW_EN to capture the ALS high byte when the
// low byte is read, so a 0x0C/0x0D burst returns a coherent 16-bit value.
module ap3216_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h1E,
  parameter int unsigned FILTER_LEN  = 3,
  parameter logic [7:0]  SYS_CFG_RST = 8'h00
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_scl,
  input  logic        I_sda,
  output logic        O_sda_oe,
  input  logic [15:0] I_als_data,
  output logic [7:0]  O_sys_cfg,
  output logic        O_cfg_wr,
  output logic        O_busy
);

  localparam int unsigned CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG_PTR, PTR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  logic [1:0]    scl_s, sda_s;
  logic [CW-1:0] scl_cnt, sda_cnt;
  logic          scl_f, sda_f, scl_d, sda_d;
  logic          scl_rise, scl_fall, start_det, stop_det;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [6:0]    shift;
  logic [6:0]    tx;
  logic [7:0]    ptr;
  logic          rw;
  logic          ack_half;
  logic [7:0]    rx_byte;
  logic [7:0]    rd_data;

  // Synchroniser plus stability filter: a filtered level only follows the
  // synchronised line after FILTER_LEN consecutive samples of the new value.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      scl_s   <= 2'b11;
      sda_s   <= 2'b11;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_d   <= 1'b1;
      sda_d   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      scl_s <= {scl_s[0], I_scl};
      sda_s <= {sda_s[0], I_sda};
      scl_d <= scl_f;
      sda_d <= sda_f;
      if (scl_s[1] == scl_f) scl_cnt <= '0;
      else if (scl_cnt == CNT_MAX) begin
        scl_f   <= scl_s[1];
        scl_cnt <= '0;
      end else scl_cnt <= scl_cnt + 1'b1;
      if (sda_s[1] == sda_f) sda_cnt <= '0;
      else if (sda_cnt == CNT_MAX) begin
        sda_f   <= sda_s[1];
        sda_cnt <= '0;
      end else sda_cnt <= sda_cnt + 1'b1;
    end
  end

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
  assign rx_byte   = {shift, sda_f};

`ifdef AP3216_SHADOW_EN
  logic [7:0] als_hi_shadow;
  logic       rd_load;

  assign rd_load = ~start_det & ~stop_det & scl_fall & ack_half &
                   (((state == ADDR_ACK) & rw) | (state == RD_ACK));

  always_ff @(posedge I_clk) begin
    if (I_rst) als_hi_shadow <= '0;
    else if (rd_load && ptr == 8'h0C) als_hi_shadow <= I_als_data[15:8];
  end
`endif

  always_comb begin
    rd_data = '0;
    case (ptr)
      8'h00: rd_data = O_sys_cfg;
      8'h0C: rd_data = I_als_data[7:0];
`ifdef AP3216_SHADOW_EN
      8'h0D: rd_data = als_hi_shadow;
`else
      8'h0D: rd_data = I_als_data[15:8];
`endif
      default: rd_data = '0;
    endcase
  end

  // ACK states use ack_half: the first SCL fall starts driving ACK, the second
  // (end of the ninth clock) releases it and moves on. In RD_ACK it marks that
  // the master ACKed, so the next byte is loaded on the following fall.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state     <= IDLE;
      O_sda_oe  <= 1'b0;
      O_sys_cfg <= SYS_CFG_RST;
      O_cfg_wr  <= 1'b0;
      O_busy    <= 1'b0;
      ptr       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      tx        <= '0;
      rw        <= 1'b0;
      ack_half  <= 1'b0;
    end else begin
      O_cfg_wr <= 1'b0;
      if (scl_rise) shift <= rx_byte[6:0];
      if (start_det) begin
        state    <= ADDR;
        O_busy   <= 1'b1;
        O_sda_oe <= 1'b0;
        bit_cnt  <= '0;
        ack_half <= 1'b0;
      end else if (stop_det) begin
        state    <= IDLE;
        O_busy   <= 1'b0;
        O_sda_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: if (scl_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              ack_half <= 1'b0;
              rw       <= rx_byte[0];
              state    <= (rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
            end
          end
          REG_PTR: if (scl_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              ptr      <= rx_byte;
              ack_half <= 1'b0;
              state    <= PTR_ACK;
            end
          end
          WR_BYTE: if (scl_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              if (ptr == 8'h00) begin
                O_sys_cfg <= rx_byte;
                O_cfg_wr  <= 1'b1;
              end
              ack_half <= 1'b0;
              state    <= WR_ACK;
            end
          end
          ADDR_ACK, PTR_ACK, WR_ACK: if (scl_fall) begin
            if (!ack_half) begin
              O_sda_oe <= 1'b1;
              ack_half <= 1'b1;
            end else begin
              ack_half <= 1'b0;
              bit_cnt  <= '0;
              if (state == ADDR_ACK && rw) begin
                tx       <= rd_data[6:0];
                O_sda_oe <= ~rd_data[7];
                state    <= RD_BYTE;
              end else begin
                O_sda_oe <= 1'b0;
                if (state == ADDR_ACK) state <= REG_PTR;
                else begin
                  if (state == WR_ACK) ptr <= ptr + 8'd1;
                  state <= WR_BYTE;
                end
              end
            end
          end
          RD_BYTE: if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              O_sda_oe <= 1'b0;
              ack_half <= 1'b0;
              state    <= RD_ACK;
            end else begin
              O_sda_oe <= ~tx[6];
              tx       <= {tx[5:0], 1'b0};
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_f) state <= IGNORE;
              else begin
                ptr      <= ptr + 8'd1;
                ack_half <= 1'b1;
              end
            end else if (scl_fall && ack_half) begin
              tx       <= rd_data[6:0];
              O_sda_oe <= ~rd_data[7];
              bit_cnt  <= '0;
              ack_half <= 1'b0;
              state    <= RD_BYTE;
            end
          end
          IGNORE: O_sda_oe <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ap3216_i2c_responder.sv
// tb_ap3216_i2c_responder: bit-banged I2C master driving ap3216_i2c_responder.
// Read-back bytes are predicted into a scoreboard queue when a read is set up
// and popped when the bytes arrive on the bus.
module tb_ap3216_i2c_responder;

  localparam int Q = 150;  // SCL low quarter / setup time
  localparam int H = 300;  // SCL high time

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic [15:0] als = 16'h0000;
  logic        sda_oe;
  logic [7:0]  sys_cfg;
  logic        cfg_wr;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cfg_cnt  = 0;
  int viol     = 0;
  logic oe_seen = 1'b0;
  logic oe_prev = 1'b0;
  logic rst_d   = 1'b1;
  logic [7:0] exp_q[$];

  assign sda_line = sda_m & ~sda_oe;

  ap3216_i2c_responder #(
    .DEV_ADDR   (7'h1E),
    .FILTER_LEN (3),
    .SYS_CFG_RST(8'h00)
  ) dut (
    .I_clk     (clk),
    .I_rst     (rst),
    .I_scl     (scl_m),
    .I_sda     (sda_line),
    .O_sda_oe  (sda_oe),
    .I_als_data(als),
    .O_sys_cfg (sys_cfg),
    .O_cfg_wr  (cfg_wr),
    .O_busy    (busy)
  );

  always #5 clk = ~clk;

  // Bus monitors: cfg_wr pulse count, any SDA drive, and SDA changing while SCL high.
  always @(negedge clk) begin
    if (cfg_wr) cfg_cnt++;
    if (sda_oe) oe_seen = 1'b1;
    if (sda_oe !== oe_prev && scl_m && !rst && !rst_d) viol++;
    oe_prev = sda_oe;
    rst_d   = rst;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #H;
    sda_m = 1'b0; #H;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #H;
    sda_m = 1'b1; #H;
  endtask

  task automatic wr_bit(input logic b);
    sda_m = b; #Q;
    scl_m = 1'b1; #H;
    scl_m = 1'b0; #Q;
  endtask

  task automatic rd_bit(output logic b);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #(H/2);
    b = sda_line; #(H/2);
    scl_m = 1'b0; #Q;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(ack);
  endtask

  // Reads a byte, applies new_als before the acknowledge bit, then scores it.
  task automatic rd_byte_sb(input logic nack, input logic [15:0] new_als, input string tag);
    logic [7:0] d;
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      rd_bit(b);
      d = {d[6:0], b};
    end
    als = new_als;
    wr_bit(nack);
    check({tag, "_sb_avail"}, 16'(exp_q.size() != 0), 16'd1);
    if (exp_q.size() != 0) check(tag, {8'h00, d}, {8'h00, exp_q.pop_front()});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic ack;
    int   cnt0;

    idle(5);
    rst = 1'b0;
    idle(2);
    check("rst_oe", {15'd0, sda_oe}, 16'd0);
    check("rst_sys_cfg", {8'h00, sys_cfg}, 16'h0000);
    check("rst_cfg_wr", {15'd0, cfg_wr}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);

    // Write 0x03 to register 0x00.
    i2c_start();
    check("busy_after_start", {15'd0, busy}, 16'd1);
    wr_byte(8'h3C, ack); check("w1_addr_ack", {15'd0, ack}, 16'd0);
    wr_byte(8'h00, ack); check("w1_ptr_ack", {15'd0, ack}, 16'd0);
    wr_byte(8'h03, ack); check("w1_data_ack", {15'd0, ack}, 16'd0);
    i2c_stop();
    idle(10);
    check("w1_sys_cfg", {8'h00, sys_cfg}, 16'h0003);
    check("w1_cfg_pulses", 16'(cfg_cnt), 16'd1);
    check("w1_busy_after_stop", {15'd0, busy}, 16'd0);

    // ALS burst read with the value changing between the two bytes.
    als = 16'h0ABC;
    exp_q.push_back(8'hBC);
`ifdef AP3216_SHADOW_EN
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(8'h0F);
`endif
    i2c_start();
    wr_byte(8'h3C, ack); check("als_addr_ack", {15'd0, ack}, 16'd0);
    wr_byte(8'h0C, ack); check("als_ptr_ack", {15'd0, ack}, 16'd0);
    i2c_start();
    wr_byte(8'h3D, ack); check("als_rd_addr_ack", {15'd0, ack}, 16'd0);
    rd_byte_sb(1'b0, 16'h0F00, "als_lo");
    rd_byte_sb(1'b1, 16'h0F00, "als_hi");
    idle(20);
    check("als_released_after_nack", {15'd0, sda_oe}, 16'd0);
    i2c_stop();
    idle(10);
    check("als_busy_after_stop", {15'd0, busy}, 16'd0);

    // Foreign address: never acknowledged, nothing written.
    idle(2);
    oe_seen = 1'b0;
    i2c_start();
    wr_byte(8'h3E, ack); check("bad_addr_nack", {15'd0, ack}, 16'd1);
    wr_byte(8'h00, ack); check("bad_ptr_nack", {15'd0, ack}, 16'd1);
    wr_byte(8'h55, ack); check("bad_data_nack", {15'd0, ack}, 16'd1);
    check("bad_busy_until_stop", {15'd0, busy}, 16'd1);
    i2c_stop();
    idle(10);
    check("bad_oe_never", {15'd0, oe_seen}, 16'd0);
    check("bad_sys_cfg", {8'h00, sys_cfg}, 16'h0003);

    // Pointer wrap on read: 0xFF then 0x00.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h03);
    i2c_start();
    wr_byte(8'h3C, ack); check("wrap_addr_ack", {15'd0, ack}, 16'd0);
    wr_byte(8'hFF, ack); check("wrap_ptr_ack", {15'd0, ack}, 16'd0);
    i2c_start();
    wr_byte(8'h3D, ack); check("wrap_rd_addr_ack", {15'd0, ack}, 16'd0);
    rd_byte_sb(1'b0, als, "wrap_ff");
    rd_byte_sb(1'b1, als, "wrap_00");
    i2c_stop();

    // Read with no pointer write uses the preserved pointer (0x00).
    exp_q.push_back(8'h03);
    i2c_start();
    wr_byte(8'h3D, ack); check("keep_addr_ack", {15'd0, ack}, 16'd0);
    rd_byte_sb(1'b1, als, "keep_ptr");
    i2c_stop();

    // Write to a read-only register is ACKed and dropped.
    cnt0 = cfg_cnt;
    i2c_start();
    wr_byte(8'h3C, ack);
    wr_byte(8'h0C, ack);
    wr_byte(8'h77, ack); check("ro_data_ack", {15'd0, ack}, 16'd0);
    i2c_stop();
    idle(10);
    check("ro_sys_cfg", {8'h00, sys_cfg}, 16'h0003);
    check("ro_no_pulse", 16'(cfg_cnt - cnt0), 16'd0);

    // Write auto-increment wraps 0xFF -> 0x00.
    i2c_start();
    wr_byte(8'h3C, ack);
    wr_byte(8'hFF, ack);
    wr_byte(8'hAA, ack); check("wwrap_ff_ack", {15'd0, ack}, 16'd0);
    wr_byte(8'h5A, ack); check("wwrap_00_ack", {15'd0, ack}, 16'd0);
    i2c_stop();
    idle(10);
    check("wwrap_sys_cfg", {8'h00, sys_cfg}, 16'h005A);
    check("wwrap_one_pulse", 16'(cfg_cnt - cnt0), 16'd1);

    // Two-cycle SDA glitch is filtered; a longer low is a real START.
    idle(5);
    sda_m = 1'b0; idle(2); sda_m = 1'b1;
    idle(20);
    check("glitch_no_start", {15'd0, busy}, 16'd0);
    sda_m = 1'b0; idle(12);
    check("long_low_start", {15'd0, busy}, 16'd1);
    sda_m = 1'b1; idle(12);
    check("long_low_stop", {15'd0, busy}, 16'd0);

    // Reset while the address ACK is being driven.
    i2c_start();
    for (int i = 7; i >= 0; i--) wr_bit(logic'(8'h3C >> i));
    check("rst_ack_driven", {15'd0, sda_oe}, 16'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    check("rst_mid_oe", {15'd0, sda_oe}, 16'd0);
    check("rst_mid_sys_cfg", {8'h00, sys_cfg}, 16'h0000);
    @(negedge clk) rst = 1'b0;
    rd_bit(ack);
    i2c_stop();
    idle(10);
    check("rst_mid_busy", {15'd0, busy}, 16'd0);
    check("sda_stable_scl_high", 16'(viol), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
